// File: rtl/rs_fifo_pkg.sv
// rtl/rs_fifo_pkg.sv - default geometry and error flag indices for the RS correction buffer
package rs_fifo_pkg;

  localparam int DW       = 64;
  localparam int SW       = 12;
  localparam int WPS      = 2;
  localparam int CW_WORDS = SW * WPS;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UNDR = 1;

endpackage

// File: rtl/rs_ptr_ring.sv
// rtl/rs_ptr_ring.sv - wrap-bit write/apply/read pointer triple with full, empty and level
module rs_ptr_ring #(
  parameter int A = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_inc_i,
  input  logic       aw_inc_i,
  input  logic       rd_inc_i,
  output logic [A:0] wr_o,
  output logic [A:0] aw_o,
  output logic [A:0] rd_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [A:0] level_o
);

  localparam int PW = A + 1;

  logic [A:0] wr_q, aw_q, rd_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      aw_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_inc_i) wr_q <= wr_q + PW'(1);
      if (aw_inc_i) aw_q <= aw_q + PW'(1);
      if (rd_inc_i) rd_q <= rd_q + PW'(1);
    end
  end

  assign wr_o    = wr_q;
  assign aw_o    = aw_q;
  assign rd_o    = rd_q;
  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign full_o  = (wr_q == {~rd_q[A], rd_q[A-1:0]});
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;

endmodule

// File: rtl/rs_corr_fifo.sv
// rtl/rs_corr_fifo.sv - codeword buffer applying decoder XOR corrections before words may be popped
module rs_corr_fifo #(
  parameter int DW  = rs_fifo_pkg::DW,
  parameter int AW  = 5,
  parameter int SW  = rs_fifo_pkg::SW,
  parameter int WPS = rs_fifo_pkg::WPS,
  parameter int CAW = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_vld,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic [SW-1:0] push_sync,
  output logic          push_rdy,
  input  logic          corr_vld,
  input  logic [DW-1:0] corr_data,
  input  logic          corr_last,
  input  logic [SW-1:0] corr_sync,
  input  logic          corr_fail,
  input  logic          pop_ena,
  output logic          pop_rdy,
  output logic          pop_vld,
  output logic [DW-1:0] pop_data,
  output logic          pop_sync,
  output logic          pop_fail,
  output logic [AW:0]   level,
  output logic [1:0]    err_flags,
  input  logic          err_clr
);

  localparam int CW_WORDS = SW * WPS;
  localparam int DEPTH    = 2 ** AW;
  localparam int CDEPTH   = 2 ** CAW;
  localparam int WIW      = $clog2(CW_WORDS);
  localparam int SIW      = $clog2(SW);

  logic [AW:0]  wr, aw, rd;
  logic [CAW:0] cwr, caw, crd;
  logic         data_full, cw_full, data_empty_unused, cw_empty_unused;
  logic [CAW:0] cw_level_unused;
  logic         push_acc, corr_acc, pop_acc, cw_done;
  logic [WIW-1:0] widx_q, widx_d;
  logic [SIW-1:0] sync_sel;
  logic [1:0]     err_q, err_d;
  logic           pop_vld_q, pop_sync_q, pop_fail_q;
  logic [DW-1:0]  pop_data_q;

  logic [DW-1:0] ram      [DEPTH];
  logic [SW-1:0] sync_ram [CDEPTH];
  logic          fail_ram [CDEPTH];

  assign push_rdy = !data_full && !(push_last && cw_full);
  assign pop_rdy  = (rd != aw);
  assign push_acc = push_vld && push_rdy;
  assign corr_acc = corr_vld && (aw != wr);
  assign pop_acc  = pop_ena && pop_rdy;
  assign cw_done  = pop_acc && (widx_q == WIW'(CW_WORDS - 1));
  assign sync_sel = SIW'(SW - 1 - int'(widx_q) / WPS);

  rs_ptr_ring #(.A(AW)) u_data_ring (
    .clk(clk), .rstn(rstn),
    .wr_inc_i(push_acc), .aw_inc_i(corr_acc), .rd_inc_i(pop_acc),
    .wr_o(wr), .aw_o(aw), .rd_o(rd),
    .full_o(data_full), .empty_o(data_empty_unused), .level_o(level)
  );

  rs_ptr_ring #(.A(CAW)) u_cw_ring (
    .clk(clk), .rstn(rstn),
    .wr_inc_i(push_acc && push_last), .aw_inc_i(corr_acc && corr_last), .rd_inc_i(cw_done),
    .wr_o(cwr), .aw_o(caw), .rd_o(crd),
    .full_o(cw_full), .empty_o(cw_empty_unused), .level_o(cw_level_unused)
  );

  // Push and correction never share an address: aw != wr on registered pointers.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      ram[wr[AW-1:0]] <= push_data;
      if (push_last) begin
        sync_ram[cwr[CAW-1:0]] <= push_sync;
        fail_ram[cwr[CAW-1:0]] <= 1'b0;
      end
    end
    if (corr_acc) begin
      ram[aw[AW-1:0]] <= ram[aw[AW-1:0]] ^ corr_data;
      if (corr_last) begin
        sync_ram[caw[CAW-1:0]] <= sync_ram[caw[CAW-1:0]] ^ corr_sync;
        fail_ram[caw[CAW-1:0]] <= corr_fail;
      end
    end
  end

  always_comb begin
    widx_d = widx_q;
    if (cw_done)      widx_d = '0;
    else if (pop_acc) widx_d = widx_q + WIW'(1);
    err_d = err_q;
    if (push_vld && !push_rdy)  err_d[rs_fifo_pkg::ERR_OVF]  = 1'b1;
    if (corr_vld && (aw == wr)) err_d[rs_fifo_pkg::ERR_UNDR] = 1'b1;
    if (err_clr)                err_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      widx_q     <= '0;
      err_q      <= '0;
      pop_vld_q  <= 1'b0;
      pop_data_q <= '0;
      pop_sync_q <= 1'b0;
      pop_fail_q <= 1'b0;
    end else begin
      widx_q    <= widx_d;
      err_q     <= err_d;
      pop_vld_q <= pop_acc;
      if (pop_acc) begin
        pop_data_q <= ram[rd[AW-1:0]];
        pop_sync_q <= sync_ram[crd[CAW-1:0]][sync_sel];
        pop_fail_q <= fail_ram[crd[CAW-1:0]];
      end else begin
        pop_sync_q <= 1'b0;
        pop_fail_q <= 1'b0;
      end
    end
  end

  assign pop_vld   = pop_vld_q;
  assign pop_data  = pop_data_q;
  assign pop_sync  = pop_sync_q;
  assign pop_fail  = pop_fail_q;
  assign err_flags = err_q;

endmodule
